glitch_sequencer: RTL and testbench

GLITCH_SEQUENCER -- requirements
Module: glitch_sequencer

---
 rtl/glitch_sequencer.sv | 152 +++++++++++++++
 tb/tb_glitch_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/glitch_sequencer.sv
// Trigger-relative glitch pulse sequencer: synchronised trigger rise -> programmable offset, width, repeat count and gap.
// Latency: trigger pin to COUNT is SYNC_STAGES+1 clocks; config is only accepted in IDLE/DONE (cfg_ready low during a run).
module glitch_sequencer #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             trigger,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_cycle,
    input  logic [7:0]       cfg_width,
    input  logic [3:0]       cfg_repeat,
    input  logic [7:0]       cfg_gap,
    input  logic             abort,
    output logic             glitch_en,
    output logic [CNT_W-1:0] cycle_count,
    output logic [4:0]       pulse_count,
    output logic [2:0]       state,
    output logic             done,
    output logic             aborted
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ARMED = 3'd1;
    localparam logic [2:0] ST_COUNT = 3'd2;
    localparam logic [2:0] ST_PULSE = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    // A single-flop synchroniser is never safe, so the chain is clamped to two.
    localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef struct packed {
        logic [CNT_W-1:0] cycle;
        logic [7:0]       width;
        logic [3:0]       rpt;
        logic [7:0]       gap;
    } cfg_t;

    cfg_t              cfg_q;
    logic [SYNC_N-1:0] sync_q;
    logic              trig_prev;
    logic [7:0]        phase_cnt;

    logic              trig_s;
    logic              trig_rise;
    logic              cfg_fire;
    logic              run_stop;
    logic [7:0]        width_m1;
    logic [7:0]        gap_m1;
    logic [CNT_W-1:0]  count_inc;

    assign trig_s    = sync_q[SYNC_N-1];
    assign trig_rise = trig_s & ~trig_prev;
    assign cfg_ready = (state == ST_IDLE) || (state == ST_DONE);
    assign cfg_fire  = cfg_valid & cfg_ready;
    assign done      = (state == ST_DONE);
    // Once counting has started, losing the trigger level is treated like a software abort.
    assign run_stop  = abort | ~trig_s;
    assign width_m1  = (cfg_q.width == 8'd0) ? 8'd0 : cfg_q.width - 8'd1;
    assign gap_m1    = (cfg_q.gap == 8'd0) ? 8'd0 : cfg_q.gap - 8'd1;
    assign count_inc = (cycle_count == {CNT_W{1'b1}}) ? cycle_count : cycle_count + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            glitch_en   <= 1'b0;
            cycle_count <= '0;
            pulse_count <= '0;
            aborted     <= 1'b0;
            sync_q      <= '0;
            trig_prev   <= 1'b0;
            cfg_q       <= '0;
            phase_cnt   <= '0;
        end else begin
            sync_q    <= {sync_q[SYNC_N-2:0], trigger};
            trig_prev <= trig_s;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (cfg_fire) begin
                        cfg_q       <= {cfg_cycle, cfg_width, cfg_repeat, cfg_gap};
                        aborted     <= 1'b0;
                        pulse_count <= '0;
                        cycle_count <= '0;
                        state       <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (abort) begin
                        aborted <= 1'b1;
                        state   <= ST_DONE;
                    end else if (trig_rise) begin
                        cycle_count <= '0;
                        state       <= ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    cycle_count <= count_inc;
                    if (run_stop) begin
                        aborted <= 1'b1;
                        state   <= ST_DONE;
                    end else if (cycle_count == cfg_q.cycle) begin
                        glitch_en   <= 1'b1;
                        pulse_count <= pulse_count + 5'd1;
                        phase_cnt   <= width_m1;
                        state       <= ST_PULSE;
                    end
                end
                ST_PULSE: begin
                    cycle_count <= count_inc;
                    if (run_stop) begin
                        glitch_en <= 1'b0;
                        aborted   <= 1'b1;
                        state     <= ST_DONE;
                    end else if (phase_cnt == 8'd0) begin
                        glitch_en <= 1'b0;
                        // pulse_count already includes the pulse that is ending.
                        if (pulse_count <= {1'b0, cfg_q.rpt}) begin
                            phase_cnt <= gap_m1;
                            state     <= ST_GAP;
                        end else begin
                            state <= ST_DONE;
                        end
                    end else begin
                        phase_cnt <= phase_cnt - 8'd1;
                    end
                end
                ST_GAP: begin
                    cycle_count <= count_inc;
                    if (run_stop) begin
                        aborted <= 1'b1;
                        state   <= ST_DONE;
                    end else if (phase_cnt == 8'd0) begin
                        glitch_en   <= 1'b1;
                        pulse_count <= pulse_count + 5'd1;
                        phase_cnt   <= width_m1;
                        state       <= ST_PULSE;
                    end else begin
                        phase_cnt <= phase_cnt - 8'd1;
                    end
                end
                default: begin
                    glitch_en <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_glitch_sequencer.sv
// Bench for glitch_sequencer: directed and random runs against a closed-form timeline model of each run.
module tb_glitch_sequencer;

    localparam int CW = 16;
    localparam int S  = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          trigger;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [CW-1:0] cfg_cycle;
    logic [7:0]    cfg_width;
    logic [3:0]    cfg_repeat;
    logic [7:0]    cfg_gap;
    logic          abort;
    logic          glitch_en;
    logic [CW-1:0] cycle_count;
    logic [4:0]    pulse_count;
    logic [2:0]    state;
    logic          done;
    logic          aborted;

    glitch_sequencer #(.CNT_W(CW), .SYNC_STAGES(S)) dut (
        .clk(clk), .reset(reset), .trigger(trigger),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_cycle(cfg_cycle), .cfg_width(cfg_width), .cfg_repeat(cfg_repeat), .cfg_gap(cfg_gap),
        .abort(abort), .glitch_en(glitch_en), .cycle_count(cycle_count),
        .pulse_count(pulse_count), .state(state), .done(done), .aborted(aborted)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d edge=%0d", tag, got, exp, edge_n);
        end
    endtask

    // Run timeline (edge numbers): mtc = edge entering COUNT, pulse k becomes visible at start_of(k),
    // md_end = edge at which DONE becomes visible, mabt = run ended early.
    int mtc, mc, mw, mg, mr, md_end, mabt;

    function automatic int start_of(input int k);
        return mtc + 1 + mc + k * (mw + mg);
    endfunction

    task automatic check_cycle(input int m);
        int e_state, e_gl, e_pc, e_cc, e_done, e_ab, e_rdy, lim, off;
        lim  = (m < md_end) ? m : md_end - 1;
        e_pc = 0;
        for (int k = 0; k <= mr; k++)
            if (start_of(k) <= lim) e_pc++;
        if (m >= md_end) begin
            e_state = 5; e_gl = 0; e_done = 1; e_ab = mabt; e_rdy = 1;
            e_cc = (md_end > mtc) ? md_end - mtc : 0;
        end else if (m < mtc) begin
            e_state = 1; e_gl = 0; e_done = 0; e_ab = 0; e_rdy = 0; e_cc = 0;
        end else begin
            e_done = 0; e_ab = 0; e_rdy = 0; e_cc = m - mtc;
            if (m < start_of(0)) begin
                e_state = 2; e_gl = 0;
            end else begin
                off = (m - start_of(0)) % (mw + mg);
                e_state = (off < mw) ? 3 : 4;
                e_gl    = (off < mw) ? 1 : 0;
            end
        end
        if (e_cc > (1 << CW) - 1) e_cc = (1 << CW) - 1;
        check_val("state",   32'(state),       e_state);
        check_val("glitch",  32'(glitch_en),   e_gl);
        check_val("pcnt",    32'(pulse_count), e_pc);
        check_val("ccnt",    32'(cycle_count), e_cc);
        check_val("done",    32'(done),        e_done);
        check_val("aborted", 32'(aborted),     e_ab);
        check_val("ready",   32'(cfg_ready),   e_rdy);
    endtask

    task automatic reset_and_idle();
        #2 reset = 1'b1;
        #1;
        check_val("rst_glitch", 32'(glitch_en),   0);
        check_val("rst_state",  32'(state),       0);
        check_val("rst_ccnt",   32'(cycle_count), 0);
        check_val("rst_pcnt",   32'(pulse_count), 0);
        check_val("rst_done",   32'(done),        0);
        check_val("rst_abt",    32'(aborted),     0);
        check_val("rst_ready",  32'(cfg_ready),   1);
        trigger = 1'b0;
        abort   = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        // A trigger rise with no configuration transfer must leave the block idle.
        for (int i = 0; i < S + 6; i++) begin
            @(negedge clk);
            check_val("post_rst_state",  32'(state),     0);
            check_val("post_rst_glitch", 32'(glitch_en), 0);
            check_val("post_rst_ready",  32'(cfg_ready), 1);
            trigger = (i < S + 3);
        end
        trigger = 1'b0;
        repeat (S + 2) @(negedge clk);
    endtask

    // mode: 0 none, 1 abort, 2 trigger fall; the event takes effect at edge mtc+evt.
    task automatic do_run(input int c, input int w, input int r, input int g,
                          input int e_delay, input int mode, input int evt, input int rst_off);
        int mx, me, f, nat_d, ev_d, end_m;
        cfg_valid  = 1'b1;
        cfg_cycle  = CW'(c);
        cfg_width  = 8'(w);
        cfg_repeat = 4'(r);
        cfg_gap    = 8'(g);
        mx   = edge_n + 1;
        me   = mx + e_delay;
        mtc  = me + S + 1;
        mc   = c;
        mw   = (w == 0) ? 1 : w;
        mg   = (g == 0) ? 1 : g;
        mr   = r;
        nat_d = start_of(mr) + mw;
        ev_d  = mtc + evt;
        if (mode != 0 && ev_d <= nat_d) begin
            md_end = ev_d; mabt = 1;
        end else begin
            md_end = nat_d; mabt = 0;
        end
        f     = (mode == 2) ? ev_d - S - 1 : 32'h7fff_ffff;
        end_m = md_end + S + 3;
        for (int m = mx; m <= end_m; m++) begin
            @(negedge clk);
            if (m == mx) begin
                cfg_valid  = 1'b0;
                cfg_cycle  = CW'($urandom);
                cfg_width  = 8'($urandom);
                cfg_repeat = 4'($urandom);
                cfg_gap    = 8'($urandom);
            end
            check_cycle(m);
            if (rst_off >= 0 && m == mtc + rst_off) begin
                reset_and_idle();
                return;
            end
            trigger = (m >= me) && (m < f) && (m < md_end);
            abort   = (mode == 1) && (m == ev_d - 1);
        end
        trigger = 1'b0;
        abort   = 1'b0;
    endtask

    initial begin
        int c, w, r, g, ed, mode, evt, lo, hi, nat_len;
        reset = 1'b0; trigger = 1'b0; cfg_valid = 1'b0; abort = 1'b0;
        cfg_cycle = '0; cfg_width = '0; cfg_repeat = '0; cfg_gap = '0;
        #1 reset = 1'b1;
        #1;
        check_val("init_state",  32'(state),       0);
        check_val("init_glitch", 32'(glitch_en),   0);
        check_val("init_ccnt",   32'(cycle_count), 0);
        check_val("init_pcnt",   32'(pulse_count), 0);
        check_val("init_done",   32'(done),        0);
        check_val("init_abt",    32'(aborted),     0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_val("first_ready", 32'(cfg_ready), 1);
        check_val("first_state", 32'(state),     0);
        repeat (2) @(negedge clk);

        do_run(613, 1, 0, 0, 2, 0, 0, -1);    // long offset, single 1-cycle pulse
        do_run(5, 3, 2, 4, 1, 0, 0, -1);      // three 3-cycle pulses, 4-cycle gaps
        do_run(0, 0, 0, 0, 0, 0, 0, -1);      // zero offset, zero width
        do_run(100, 1, 0, 0, 3, 2, 50, -1);   // trigger falls at count 50
        do_run(7, 4, 0, 0, 1, 1, 10, -1);     // abort on second pulse cycle
        do_run(3, 2, 3, 0, 0, 0, 0, -1);      // zero gap re-arms after one low cycle
        do_run(2, 2, 1, 1, 0, 1, 8, -1);      // abort coincides with final pulse end
        do_run(10, 1, 0, 0, 2, 1, -1, -1);    // abort while armed
        do_run(2, 1, 0, 0, 0, 1, 6, -1);      // abort after DONE has no effect
        do_run(0, 1, 15, 0, 0, 0, 0, -1);     // sixteen pulses

        for (int i = 0; i < 40; i++) begin
            c    = int'($urandom_range(0, 30));
            w    = int'($urandom_range(0, 6));
            r    = int'($urandom_range(0, 15));
            g    = int'($urandom_range(0, 6));
            ed   = int'($urandom_range(0, 4));
            mode = int'($urandom_range(0, 2));
            nat_len = 1 + c + r * (((w == 0) ? 1 : w) + ((g == 0) ? 1 : g)) + ((w == 0) ? 1 : w);
            lo  = (mode == 1) ? -(ed + S) : 1;
            hi  = nat_len + 3;
            evt = lo + int'($urandom_range(0, hi - lo));
            do_run(c, w, r, g, ed, mode, evt, -1);
        end

        do_run(3, 2, 3, 10, 0, 0, 0, 4);      // reset during the first pulse
        do_run(3, 2, 3, 10, 0, 0, 0, 9);      // reset during a gap
        do_run(4, 2, 1, 2, 1, 0, 0, -1);      // normal run after reset

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
